// File: rtl/ysyx_23060229_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction over an AR/R read
// channel, hands it to decode, then waits for execute to commit the next PC.
module ysyx_23060229_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        commit,
   input  logic [31:0] dnpc,
   output logic        fetch_err,
   output logic [31:0] retire_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AR   = 3'd1,
      R    = 3'd2,
      OUT  = 3'd3,
      EXEC = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_retire;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_inst_valid;
   logic        r_fetch_err;

   logic        w_dnpc_aligned;
   logic        w_resp_ok;

   assign w_dnpc_aligned = (dnpc[1:0] == 2'b00);
   assign w_resp_ok      = (rresp == 2'b00);

   // Output flags are registered alongside the state so each equals (state == X).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_inst       <= NOP;
         r_retire     <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_inst_valid <= 1'b0;
         r_fetch_err  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_state   <= AR;
               r_arvalid <= 1'b1;
            end
            AR: begin
               if (arready) begin
                  r_state   <= R;
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            R: begin
               if (rvalid) begin
                  r_rready <= 1'b0;
                  if (w_resp_ok) begin
                     r_inst       <= rdata;
                     r_state      <= OUT;
                     r_inst_valid <= 1'b1;
                  end else begin
                     r_state     <= ERR;
                     r_fetch_err <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (inst_ready) begin
                  r_state      <= EXEC;
                  r_inst_valid <= 1'b0;
               end
            end
            EXEC: begin
               if (commit) begin
                  // A misaligned target is still recorded in pc for debug.
                  r_pc     <= dnpc;
                  r_retire <= r_retire + 32'd1;
                  if (w_dnpc_aligned) begin
                     r_state   <= AR;
                     r_arvalid <= 1'b1;
                  end else begin
                     r_state     <= ERR;
                     r_fetch_err <= 1'b1;
                  end
               end
            end
            ERR: begin
               r_state <= ERR;
            end
            default: begin
               r_state      <= ERR;
               r_arvalid    <= 1'b0;
               r_rready     <= 1'b0;
               r_inst_valid <= 1'b0;
               r_fetch_err  <= 1'b1;
            end
         endcase
      end
   end

   assign araddr     = r_pc;
   assign inst_pc    = r_pc;
   assign inst       = r_inst;
   assign arvalid    = r_arvalid;
   assign rready     = r_rready;
   assign inst_valid = r_inst_valid;
   assign fetch_err  = r_fetch_err;
   assign retire_cnt = r_retire;

endmodule

// File: tb/tb_ysyx_23060229_ifu.sv
// Directed bench for ysyx_23060229_ifu: table of zero-wait cycles plus
// hand-written backpressure, async-reset and fault sequences.
module tb_ysyx_23060229_ifu;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        commit;
   logic [31:0] dnpc;
   logic        fetch_err;
   logic [31:0] retire_cnt;

   int unsigned n_cmp;
   int unsigned n_err;

   ysyx_23060229_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .commit     (commit),
      .dnpc       (dnpc),
      .fetch_err  (fetch_err),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ar;
      logic        rv;
      logic [1:0]  resp;
      logic [31:0] rd;
      logic        ir;
      logic        cm;
      logic [31:0] np;
      logic        e_arv;
      logic        e_rr;
      logic        e_iv;
      logic        e_err;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic ar, rv, input logic [31:0] rd, input logic ir, cm,
                               input logic [31:0] np, input logic e_arv, e_rr, e_iv,
                               input logic [31:0] e_pc, e_inst, e_cnt);
      vec_t v;
      v.ar = ar; v.rv = rv; v.resp = 2'b00; v.rd = rd; v.ir = ir; v.cm = cm; v.np = np;
      v.e_arv = e_arv; v.e_rr = e_rr; v.e_iv = e_iv; v.e_err = 1'b0;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic e_arv, e_rr, e_iv, e_err,
                          input logic [31:0] e_pc, e_inst, e_cnt);
      chk({nm, ".arvalid"},    {31'd0, arvalid},    {31'd0, e_arv});
      chk({nm, ".rready"},     {31'd0, rready},     {31'd0, e_rr});
      chk({nm, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_iv});
      chk({nm, ".fetch_err"},  {31'd0, fetch_err},  {31'd0, e_err});
      chk({nm, ".araddr"},     araddr,              e_pc);
      chk({nm, ".inst_pc"},    inst_pc,             e_pc);
      chk({nm, ".inst"},       inst,                e_inst);
      chk({nm, ".retire_cnt"}, retire_cnt,          e_cnt);
   endtask

   task automatic drive(input logic ar, rv, input logic [1:0] resp, input logic [31:0] rd,
                        input logic ir, cm, input logic [31:0] np);
      arready = ar; rvalid = rv; rresp = resp; rdata = rd;
      inst_ready = ir; commit = cm; dnpc = np;
   endtask

   task automatic reset_cycles(input int unsigned n);
      rst = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         step();
         chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0,
                 32'h8000_0000, 32'h0000_0013, 32'd0);
      end
      rst = 1'b1;
   endtask

   vec_t tv[15];

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0);

      // Zero-wait flow, branch, and spurious commits in AR / OUT.
      tv[0]  = mk(1,1,32'h0010_0093,1,0,32'h0,         1,0,0, 32'h8000_0000,32'h0000_0013,0);
      tv[1]  = mk(1,1,32'h0010_0093,1,0,32'h0,         0,1,0, 32'h8000_0000,32'h0000_0013,0);
      tv[2]  = mk(1,1,32'h0010_0093,1,0,32'h0,         0,0,1, 32'h8000_0000,32'h0010_0093,0);
      tv[3]  = mk(1,1,32'h0010_0093,1,0,32'h0,         0,0,0, 32'h8000_0000,32'h0010_0093,0);
      tv[4]  = mk(1,1,32'h0010_0093,1,1,32'h8000_0004, 1,0,0, 32'h8000_0004,32'h0010_0093,1);
      tv[5]  = mk(1,1,32'h0020_0113,1,0,32'h0,         0,1,0, 32'h8000_0004,32'h0010_0093,1);
      tv[6]  = mk(1,1,32'h0020_0113,1,0,32'h0,         0,0,1, 32'h8000_0004,32'h0020_0113,1);
      tv[7]  = mk(1,1,32'h0020_0113,1,0,32'h0,         0,0,0, 32'h8000_0004,32'h0020_0113,1);
      tv[8]  = mk(1,1,32'h0020_0113,1,1,32'h8000_0100, 1,0,0, 32'h8000_0100,32'h0020_0113,2);
      tv[9]  = mk(1,1,32'hAABB_CCDD,1,1,32'h1234_5678, 0,1,0, 32'h8000_0100,32'h0020_0113,2);
      tv[10] = mk(1,1,32'hAABB_CCDD,1,0,32'h0,         0,0,1, 32'h8000_0100,32'hAABB_CCDD,2);
      tv[11] = mk(1,1,32'h1111_1111,0,1,32'h1234_5678, 0,0,1, 32'h8000_0100,32'hAABB_CCDD,2);
      tv[12] = mk(1,1,32'h1111_1111,1,0,32'h0,         0,0,0, 32'h8000_0100,32'hAABB_CCDD,2);
      tv[13] = mk(1,1,32'h1111_1111,1,0,32'h0,         0,0,0, 32'h8000_0100,32'hAABB_CCDD,2);
      tv[14] = mk(1,1,32'h1111_1111,1,1,32'h8000_0104, 1,0,0, 32'h8000_0104,32'hAABB_CCDD,3);

      #1;
      reset_cycles(3);
      for (int i = 0; i < 15; i++) begin
         drive(tv[i].ar, tv[i].rv, tv[i].resp, tv[i].rd, tv[i].ir, tv[i].cm, tv[i].np);
         step();
         chk_all($sformatf("v%0d", i), tv[i].e_arv, tv[i].e_rr, tv[i].e_iv, tv[i].e_err,
                 tv[i].e_pc, tv[i].e_inst, tv[i].e_cnt);
      end

      // Backpressure: 3 arready, 2 rvalid, 4 inst_ready wait cycles -> 4 + 9 cycles per fetch.
      begin
         int unsigned ar_w, r_w, i_w, cyc;
         logic left;
         ar_w = 3; r_w = 2; i_w = 4; cyc = 0; left = 1'b0;
         drive(1'b0, 1'b0, 2'b00, 32'h0030_0193, 1'b0, 1'b1, 32'h8000_0108);
         while (cyc < 40) begin
            arready = arvalid && (ar_w == 0);
            if (arvalid && ar_w != 0) ar_w--;
            rvalid = rready && (r_w == 0);
            if (rready && r_w != 0) r_w--;
            inst_ready = inst_valid && (i_w == 0);
            if (inst_valid && i_w != 0) i_w--;
            step();
            cyc++;
            if (!arvalid) left = 1'b1;
            else if (left) break;
            if (inst_valid) begin
               chk("bp.inst", inst, 32'h0030_0193);
               chk("bp.inst_pc", inst_pc, 32'h8000_0104);
            end else begin
               chk("bp.araddr", araddr, 32'h8000_0104);
            end
         end
         chk("bp.cycles", cyc, 32'd13);
         chk_all("bp.end", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0108, 32'h0030_0193, 32'd4);
      end

      // Async reset while in R.
      drive(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0);
      step();
      chk("ar_r.rready", {31'd0, rready}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async", 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0013, 32'd0);
      step();
      rst = 1'b1;
      drive(1'b1, 1'b1, 2'b00, 32'h0050_0293, 1'b1, 1'b0, '0);
      step();
      chk_all("restart", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0013, 32'd0);

      // Misaligned commit target.
      step(); step(); step();
      chk_all("mis.exec", 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0050_0293, 32'd0);
      drive(1'b1, 1'b1, 2'b00, 32'h0050_0293, 1'b1, 1'b1, 32'h8000_0006);
      step();
      chk_all("mis.err", 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0006, 32'h0050_0293, 32'd1);
      drive(1'b1, 1'b1, 2'b00, 32'h0050_0293, 1'b1, 1'b1, 32'h8000_0010);
      step(); step();
      chk_all("mis.hold", 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0006, 32'h0050_0293, 32'd1);

      // Error response: inst keeps prior value, no requests for 20 cycles.
      rst = 1'b0;
      step();
      rst = 1'b1;
      drive(1'b1, 1'b1, 2'b00, 32'h0060_0313, 1'b1, 1'b0, '0);
      step(); step(); step(); step();
      drive(1'b1, 1'b1, 2'b00, 32'h0060_0313, 1'b1, 1'b1, 32'h8000_0004);
      step();
      drive(1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
      step();
      chk("flt.rready", {31'd0, rready}, 32'd1);
      drive(1'b1, 1'b1, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
      step();
      chk_all("flt.err", 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h0060_0313, 32'd1);
      drive(1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h8000_0020);
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("flt.arvalid%0d", i), {31'd0, arvalid}, 32'd0);
      end
      chk_all("flt.end", 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h0060_0313, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_23060229_ifu.md
# ysyx_23060229_ifu

Instruction fetch unit for the ysyx_23060229 core, sitting directly upstream of the IDU/EXU datapath. Owns the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready read channel (AR/R style). It presents the instruction word and its PC to the decode stage with a valid/ready handshake. It then waits for the execute stage to commit a next-PC before fetching again.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = in reset)
- araddr  out  32  fetch address; equals pc
- arvalid  out  1  fetch request valid
- arready  in  1  memory accepts request
- rdata  in  32  returned instruction word
- rresp  in  2  response code; 2'b00 = OKAY, anything else = error
- rvalid  in  1  read data valid
- rready  out  1  IFU accepts read data
- inst  out  32  fetched instruction to decode
- inst_pc  out  32  PC of inst
- inst_valid  out  1  inst/inst_pc valid to decode
- inst_ready  in  1  decode accepts inst
- commit  in  1  execute stage retired current instruction (1-cycle pulse)
- dnpc  in  32  next PC from execute, sampled when commit=1
- fetch_err  out  1  sticky fetch fault flag
- retire_cnt  out  32  number of accepted commits since reset

## Operation
- State machine with 6 states: IDLE, AR, R, OUT, EXEC, ERR.
- Outputs are Moore-decoded from the state register: arvalid=(AR), rready=(R), inst_valid=(OUT), fetch_err=(ERR).
- IDLE: entered on reset; next cycle -> AR unconditionally.
- AR: araddr=pc, held stable while arvalid=1; arvalid=1 && arready=1 -> R.
- R: rvalid=1 with rresp=00 -> latch rdata into inst, go to OUT. rvalid=1 with rresp!=00 -> ERR; inst is not updated.
- OUT: inst and inst_pc held stable until inst_ready=1, then -> EXEC.
- EXEC: commit=1 -> pc<=dnpc, retire_cnt<=retire_cnt+1 (wraps 32'hFFFF_FFFF -> 0).
  - dnpc[1:0]==2'b00 -> AR.
  - dnpc[1:0]!=2'b00 -> ERR (misaligned); pc still takes dnpc for debug.
- ERR: absorbing until reset; no requests issued; pc and retire_cnt frozen.
- commit in any state other than EXEC is ignored: no pc or count change.
- inst_pc always equals pc; pc changes only in EXEC on commit or on reset.
- arready/rvalid/inst_ready outside their consuming state are ignored.
- Reset mid-transaction: state->IDLE immediately, outstanding memory request abandoned. The memory side must tolerate an unaccepted arvalid drop caused by reset only.

## Timing
- Reset values: pc=RESET_PC, inst=32'h0000_0013 (nop), retire_cnt=0, state=IDLE.
  - arvalid=0, rready=0, inst_valid=0, fetch_err=0, araddr=inst_pc=RESET_PC.
- First edge after rst deasserts: IDLE->AR; arvalid high from that cycle.
- Zero-wait memory (arready, rvalid both 1 immediately): AR 1 cycle, R 1 cycle, OUT 1 cycle if inst_ready=1.
  - inst_valid rises 2 cycles after arvalid rises.
- Minimum commit-to-next-arvalid: 1 cycle (commit sampled at edge, arvalid high the following cycle).
- Steady-state throughput with zero-wait memory and same-cycle commit: one instruction per 4 cycles (AR, R, OUT, EXEC).
- Each wait cycle of arready, rvalid or inst_ready adds exactly one cycle in the corresponding state.
- No combinational path from any input to any output.

## Test plan
- Reset/first fetch: hold rst=0 3 cycles, release with arready=rvalid=inst_ready=1, rdata=32'h0010_0093, then commit with dnpc=32'h8000_0004.
  - Outputs at reset values during reset.
  - arvalid=1 with araddr=32'h8000_0000 one cycle after release.
  - inst_valid=1 with inst=32'h0010_0093 two cycles later.
  - Next araddr=32'h8000_0004; retire_cnt=1.
- Backpressure: arready low 3 cycles, rvalid low 2 cycles, inst_ready low 4 cycles.
  - araddr and inst/inst_pc stable throughout.
  - Exactly 9 extra cycles versus the zero-wait case.
- Branch: commit with dnpc=32'h8000_0100 -> next araddr=32'h8000_0100; inst_pc updates accordingly.
- Spurious commit: pulse commit with dnpc=32'h1234_5678 during AR or OUT.
  - pc unchanged; retire_cnt unchanged.
- Faults:
  - rresp=2'b10 on rvalid -> fetch_err=1 next cycle; arvalid stays 0 for 20 cycles; inst keeps its previous value.
  - Separately, commit with dnpc=32'h8000_0006 -> fetch_err=1, pc=32'h8000_0006.
- Async reset mid-fetch: drop rst while in R.
  - All outputs return to reset values without a clock edge.
  - After release, fetch restarts at 32'h8000_0000 with retire_cnt=0.
